// File: rtl/calc1_req_driver.sv
// Request driver for one calc1 port: accepts an operation, serialises it onto the
// calc1 request bus over two cycles, waits for the reply (or a timeout) and holds the result.
module calc1_req_driver #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_cmd,
    input  logic [31:0] op_data1,
    input  logic [31:0] op_data2,
    output logic [3:0]  calc_cmd_out,
    output logic [31:0] calc_data_out,
    input  logic [1:0]  calc_resp_in,
    input  logic [31:0] calc_data_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [7:0]  stray_cnt
);

    generate
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("calc1_req_driver: TIMEOUT must be within 1..255");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND1 = 3'd1,
        SEND2 = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OK      = 2'd1;
    localparam logic [1:0] RESP_ERR     = 2'd2;
    localparam logic [1:0] RESP_TIMEOUT = 2'd3;
    localparam logic [7:0] WAIT_LAST    = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        op_ready_q;
    logic [3:0]  calc_cmd_q;
    logic [31:0] calc_data_q;
    logic [31:0] data2_q;
    logic [7:0]  wait_cnt_q;
    logic        rsp_valid_q;
    logic [1:0]  rsp_resp_q;
    logic [31:0] rsp_data_q;
    logic [7:0]  stray_cnt_q;
    logic [7:0]  stray_cnt_d;
    logic        resp_seen;

    assign resp_seen = (calc_resp_in != '0);

    // Any reply outside WAIT belongs to no operation; count it and drop it.
    always_comb begin
        stray_cnt_d = stray_cnt_q;
        if (resp_seen && (state_q != WAIT) && (stray_cnt_q != '1)) begin
            stray_cnt_d = stray_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_ready_q  <= 1'b1;
            calc_cmd_q  <= '0;
            calc_data_q <= '0;
            data2_q     <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_resp_q  <= '0;
            rsp_data_q  <= '0;
            stray_cnt_q <= '0;
        end else begin
            stray_cnt_q <= stray_cnt_d;
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        op_ready_q <= 1'b0;
                        data2_q    <= op_data2;
                        if (op_cmd != '0) begin
                            state_q     <= SEND1;
                            calc_cmd_q  <= op_cmd;
                            calc_data_q <= op_data1;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_resp_q  <= RESP_ERR;
                            rsp_data_q  <= '0;
                        end
                    end
                end
                SEND1: begin
                    state_q     <= SEND2;
                    calc_cmd_q  <= '0;
                    calc_data_q <= data2_q;
                end
                SEND2: begin
                    state_q     <= WAIT;
                    calc_data_q <= '0;
                    wait_cnt_q  <= '0;
                end
                WAIT: begin
                    // A reply arriving on the last permitted cycle beats the timeout.
                    if (resp_seen) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_resp_q  <= calc_resp_in;
                        rsp_data_q  <= calc_data_in;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_resp_q  <= RESP_TIMEOUT;
                        rsp_data_q  <= '0;
                        wait_cnt_q  <= wait_cnt_q + 8'd1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        op_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    op_ready_q  <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    calc_cmd_q  <= '0;
                    calc_data_q <= '0;
                end
            endcase
        end
    end

    assign op_ready      = op_ready_q;
    assign calc_cmd_out  = calc_cmd_q;
    assign calc_data_out = calc_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_data      = rsp_data_q;
    assign stray_cnt     = stray_cnt_q;

    // RESP_OK is the success code calc1 returns; the block forwards it untouched.
    logic unused_ok;
    assign unused_ok = ^RESP_OK;

endmodule

// File: tb/tb_calc1_req_driver.sv
// Bench for calc1_req_driver: directed scenarios plus randomized operations,
// checked against a cycle-level transaction model of the request/response protocol.
module tb_calc1_req_driver;

    localparam int unsigned TO = 16;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_cmd = '0;
    logic [31:0] op_data1 = '0;
    logic [31:0] op_data2 = '0;
    logic [3:0]  calc_cmd_out;
    logic [31:0] calc_data_out;
    logic [1:0]  calc_resp_in = '0;
    logic [31:0] calc_data_in = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic [7:0]  stray_cnt;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned exp_stray = 0;

    calc1_req_driver #(.TIMEOUT(TO)) dut (
        .c_clk(c_clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
        .op_data1(op_data1), .op_data2(op_data2),
        .calc_cmd_out(calc_cmd_out), .calc_data_out(calc_data_out),
        .calc_resp_in(calc_resp_in), .calc_data_in(calc_data_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_resp(rsp_resp), .rsp_data(rsp_data), .stray_cnt(stray_cnt)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic bump_stray();
        if (exp_stray < 255) exp_stray++;
    endtask

    task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        total++;
        if (op_ready !== 1'b1) $display("FAIL start_ready got=%b exp=1", op_ready); else passed++;
        op_valid = 1'b1; op_cmd = c; op_data1 = a; op_data2 = b;
        step();
        op_valid = 1'b0; op_cmd = 4'($urandom); op_data1 = $urandom; op_data2 = $urandom;
    endtask

    // Called just after the accept edge; runs the operation to the rsp handshake.
    task automatic finish_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                             input int unsigned delay, input logic [1:0] rv, input logic [31:0] rd,
                             input int unsigned hold, input bit stray_send);
        logic [1:0]  er;
        logic [31:0] ed;
        int unsigned nwait;
        if (c == 4'd0) begin
            er = 2'd2; ed = '0; nwait = 0;
        end else if (rv != 2'd0 && delay + 1 <= TO) begin
            er = rv; ed = rd; nwait = delay + 1;
        end else begin
            er = 2'd3; ed = '0; nwait = TO;
        end
        if (c != 4'd0) begin
            total++;
            if (calc_cmd_out !== c || calc_data_out !== a || op_ready !== 1'b0 || rsp_valid !== 1'b0)
                $display("FAIL send1 got=%h/%h rdy=%b vld=%b exp=%h/%h rdy=0 vld=0",
                         calc_cmd_out, calc_data_out, op_ready, rsp_valid, c, a);
            else passed++;
            if (stray_send) begin
                calc_resp_in = 2'd1; calc_data_in = $urandom;
                bump_stray();
            end
            step();
            calc_resp_in = '0;
            total++;
            if (calc_cmd_out !== 4'd0 || calc_data_out !== b || rsp_valid !== 1'b0)
                $display("FAIL send2 got=%h/%h vld=%b exp=0/%h vld=0", calc_cmd_out, calc_data_out, rsp_valid, b);
            else passed++;
            step();
            for (int unsigned w = 1; w <= nwait; w++) begin
                total++;
                if (calc_cmd_out !== 4'd0 || calc_data_out !== 32'd0 || rsp_valid !== 1'b0)
                    $display("FAIL wait_bus cyc=%0d got=%h/%h vld=%b exp=0/0 vld=0",
                             w, calc_cmd_out, calc_data_out, rsp_valid);
                else passed++;
                if (rv != 2'd0 && w == delay + 1) begin
                    calc_resp_in = rv; calc_data_in = rd;
                end else begin
                    calc_resp_in = '0; calc_data_in = $urandom;
                end
                step();
            end
            calc_resp_in = '0;
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_resp !== er || rsp_data !== ed || calc_cmd_out !== 4'd0 || op_ready !== 1'b0)
            $display("FAIL resp got=vld%b %0d/%h cmd=%h rdy=%b exp=vld1 %0d/%h cmd=0 rdy=0",
                     rsp_valid, rsp_resp, rsp_data, calc_cmd_out, op_ready, er, ed);
        else passed++;
        for (int unsigned h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                calc_resp_in = 2'($urandom_range(1, 3)); calc_data_in = $urandom;
                bump_stray();
            end
            step();
            calc_resp_in = '0;
            total++;
            if (rsp_valid !== 1'b1 || rsp_resp !== er || rsp_data !== ed || op_ready !== 1'b0 || calc_cmd_out !== 4'd0)
                $display("FAIL hold cyc=%0d got=vld%b %0d/%h rdy=%b cmd=%h exp=vld1 %0d/%h rdy=0 cmd=0",
                         h, rsp_valid, rsp_resp, rsp_data, op_ready, calc_cmd_out, er, ed);
            else passed++;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || op_ready !== 1'b1 || stray_cnt !== 8'(exp_stray))
            $display("FAIL release got=vld%b rdy=%b stray=%0d exp=vld0 rdy1 stray=%0d",
                     rsp_valid, op_ready, stray_cnt, exp_stray);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        exp_stray = 0;
        total++;
        if (calc_cmd_out !== 4'd0 || calc_data_out !== 32'd0 || rsp_valid !== 1'b0 || rsp_resp !== 2'd0 ||
            rsp_data !== 32'd0 || stray_cnt !== 8'd0 || op_ready !== 1'b1)
            $display("FAIL reset got=%h/%h vld%b %0d/%h stray=%0d rdy=%b exp=0/0 vld0 0/0 stray=0 rdy1",
                     calc_cmd_out, calc_data_out, rsp_valid, rsp_resp, rsp_data, stray_cnt, op_ready);
        else passed++;
        step();
        total++;
        if (op_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL reset_idle got=rdy%b vld%b exp=rdy1 vld0", op_ready, rsp_valid);
        else passed++;
    endtask

    task automatic test_add();
        start_op(4'd1, 32'h1, 32'h1FFF_FFFF);
        finish_op(4'd1, 32'h1, 32'h1FFF_FFFF, 1, 2'd1, 32'h2000_0000, 0, 1'b0);
        start_op(4'd2, 32'h55, 32'h5);
        finish_op(4'd2, 32'h55, 32'h5, 0, 2'd1, 32'h50, 0, 1'b0);
    endtask

    task automatic test_overflow();
        start_op(4'd1, 32'hFFFF_FFFF, 32'h1);
        finish_op(4'd1, 32'hFFFF_FFFF, 32'h1, 3, 2'd2, 32'h0, 1, 1'b0);
        total++;
        if (stray_cnt !== 8'(exp_stray)) $display("FAIL overflow_stray got=%0d exp=%0d", stray_cnt, exp_stray);
        else passed++;
    endtask

    task automatic test_timeout();
        start_op(4'd5, 32'hA, 32'h3);
        finish_op(4'd5, 32'hA, 32'h3, 1000, 2'd0, 32'h0, 0, 1'b0);
        start_op(4'd6, 32'h80, 32'h2);
        finish_op(4'd6, 32'h80, 32'h2, TO - 1, 2'd1, 32'h20, 0, 1'b0);
        start_op(4'd1, 32'h7, 32'h8);
        finish_op(4'd1, 32'h7, 32'h8, TO, 2'd1, 32'hF, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        start_op(4'd6, 32'hDEAD_BEEF, 32'h4);
        op_valid = 1'b1; op_cmd = 4'd2; op_data1 = 32'h100; op_data2 = 32'h1;
        finish_op(4'd6, 32'hDEAD_BEEF, 32'h4, 2, 2'd1, 32'h0DEA_DBEE, 5, 1'b0);
        total++;
        if (calc_cmd_out !== 4'd0 || op_ready !== 1'b1)
            $display("FAIL bp_pending got=cmd%h rdy%b exp=cmd0 rdy1", calc_cmd_out, op_ready);
        else passed++;
        step();
        op_valid = 1'b0;
        finish_op(4'd2, 32'h100, 32'h1, 0, 2'd1, 32'hFF, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int unsigned n = 0; n < 40; n++) begin
            logic [3:0]  c;
            logic [31:0] a, b, rd;
            logic [1:0]  rv;
            int unsigned d, h;
            bit ss;
            c  = 4'($urandom_range(0, 15));
            a  = $urandom; b = $urandom; rd = $urandom;
            rv = 2'($urandom_range(0, 3));
            d  = $urandom_range(0, TO + 2);
            h  = $urandom_range(0, 3);
            ss = 1'($urandom_range(0, 1));
            start_op(c, a, b);
            finish_op(c, a, b, d, rv, rd, h, ss);
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    task automatic test_stray_reject();
        reset = 1'b1; step(); reset = 1'b0;
        exp_stray = 0;
        for (int unsigned i = 0; i < 300; i++) begin
            calc_resp_in = 2'd1; calc_data_in = $urandom;
            step();
            bump_stray();
            if (i == 99 || i == 254 || i == 299) begin
                total++;
                if (stray_cnt !== 8'(exp_stray)) $display("FAIL stray_cnt i=%0d got=%0d exp=%0d", i, stray_cnt, exp_stray);
                else passed++;
            end
        end
        calc_resp_in = '0;
        start_op(4'd0, 32'h1234, 32'h5678);
        finish_op(4'd0, 32'h1234, 32'h5678, 0, 2'd1, 32'h0, 2, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        start_op(4'd1, 32'h11, 32'h22);
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_stray = 0;
        total++;
        if (calc_cmd_out !== 4'd0 || calc_data_out !== 32'd0 || rsp_valid !== 1'b0 || rsp_resp !== 2'd0 ||
            rsp_data !== 32'd0 || stray_cnt !== 8'd0 || op_ready !== 1'b1)
            $display("FAIL midwait_reset got=%h/%h vld%b %0d/%h stray=%0d rdy=%b exp=0/0 vld0 0/0 stray=0 rdy1",
                     calc_cmd_out, calc_data_out, rsp_valid, rsp_resp, rsp_data, stray_cnt, op_ready);
        else passed++;
        calc_resp_in = 2'd1; calc_data_in = 32'h33;
        step();
        calc_resp_in = '0;
        bump_stray();
        total++;
        if (stray_cnt !== 8'(exp_stray) || rsp_valid !== 1'b0)
            $display("FAIL late_resp got=stray%0d vld%b exp=stray%0d vld0", stray_cnt, rsp_valid, exp_stray);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_timeout();
        test_backpressure();
        test_random();
        test_stray_reject();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
